// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Turns a raster-order pixel stream into one 3x3 neighbourhood window per
//   pixel position. The window is centred on the pixel, and borders are
//   extended by zero padding or by replication.
//
//   Datapath:
//     - Two line buffers hold the previous two rows.
//     - A two-column register holds the left and centre columns.
//     - The freshly assembled right column is combined with that register.
//     - The combined 3x3 is edge-masked and then registered into m_data.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_sof   input pixel stream
//   m_valid/m_ready/m_data         output window stream. Slice
//                                  (3*i+j)*DATA_W holds pixel (r-1+i, c-1+j).
//   m_sof/m_eol/m_eof              window centred at (0,0) / last column /
//                                  last pixel
//   m_err         one-cycle pulse when s_sof arrives at a nonzero position
//   dbg_state     current FSM state (FILL=0, RUN=1, DRAIN=2)
//
// Handshake: a beat moves on a channel when valid && ready at a rising edge.
//   - Once m_valid is raised, m_data and the flags stay stable until m_ready.
//   - m_valid never depends combinationally on m_ready.
//   - s_ready is low in DRAIN, and elsewhere low only while a window is stalled.

package cfg_pkg;
  localparam string EXTEND_STRATEGY = "ZERO_PAD";
endpackage

module conv_window_gen #(
  parameter int    DATA_W = 8,
  parameter int    IMG_W  = 16,
  parameter int    IMG_H  = 16,
  parameter string EXTEND = cfg_pkg::EXTEND_STRATEGY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_sof,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [9*DATA_W-1:0]   m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  m_err,
  output logic [1:0]            dbg_state
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam bit REPL = (EXTEND == "REPLICATE");

  typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] in_c, out_c, rd_col;
  logic [RW-1:0] in_r, out_r;

  // Line buffers: lb_a holds row r-1, lb_b holds row r-2 at each column.
  logic [DATA_W-1:0] lb_a [IMG_W];
  logic [DATA_W-1:0] lb_b [IMG_W];

  // Columns indexed [row]: 0 = top, 1 = middle, 2 = bottom.
  logic [2:0][DATA_W-1:0] col_l, col_c, col_n;
  logic [2:0][2:0][DATA_W-1:0] raw, cf, fin;
  logic [9*DATA_W-1:0] win;

  logic accept, in_first, in_last, at_start, sof_err;
  logic drain_emit, produce, shift;
  logic left_oob, right_oob, top_oob, bot_oob;

  assign s_ready   = (state != DRAIN) && (!m_valid || m_ready || state == FILL);
  assign dbg_state = state;

  always_comb begin
    accept   = s_valid && s_ready;
    in_first = (in_r == '0) && (in_c == '0);
    in_last  = (in_r == R_LAST) && (in_c == C_LAST);
    at_start = (in_r == RW'(1)) && (in_c == CW'(1));
    sof_err  = accept && s_sof && !in_first;
    // Draining stops once the eof window is loaded; that window then waits for m_ready.
    drain_emit = (state == DRAIN) && (!m_valid || m_ready) && !(m_valid && m_eof);
    produce  = (accept && !sof_err && (state == RUN || (state == FILL && at_start)))
               || drain_emit;
    shift    = accept || drain_emit;
    // DRAIN feeds virtual pixels. Their column follows the output position.
    // Their bottom row is garbage, but it only reaches masked window cells.
    if (state == DRAIN)
      rd_col = (out_c == C_LAST) ? '0 : out_c + 1'b1;
    else if (sof_err)
      rd_col = '0;
    else
      rd_col = in_c;
    col_n = {s_data, lb_a[rd_col], lb_b[rd_col]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (sof_err)                 state_nxt = FILL;
        else if (accept && in_last)  state_nxt = DRAIN;
        else if (accept && at_start) state_nxt = RUN;
      end
      RUN: begin
        if (sof_err)                 state_nxt = FILL;
        else if (accept && in_last)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (m_valid && m_ready && m_eof) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Window assembly.
  // Columns are fixed first, then rows, so corners take the centre pixel under replication.
  // Masking also hides the previous row's wrap column and unreset line-buffer contents.
  always_comb begin
    raw = '0;
    cf  = '0;
    fin = '0;
    left_oob  = (out_c == '0);
    right_oob = (out_c == C_LAST);
    top_oob   = (out_r == '0);
    bot_oob   = (out_r == R_LAST);
    for (int i = 0; i < 3; i++) begin
      raw[i][0] = col_l[i];
      raw[i][1] = col_c[i];
      raw[i][2] = col_n[i];
    end
    for (int i = 0; i < 3; i++) begin
      cf[i][0] = left_oob  ? (REPL ? raw[i][1] : '0) : raw[i][0];
      cf[i][1] = raw[i][1];
      cf[i][2] = right_oob ? (REPL ? raw[i][1] : '0) : raw[i][2];
    end
    for (int j = 0; j < 3; j++) begin
      fin[0][j] = top_oob ? (REPL ? cf[1][j] : '0) : cf[0][j];
      fin[1][j] = cf[1][j];
      fin[2][j] = bot_oob ? (REPL ? cf[1][j] : '0) : cf[2][j];
    end
    // The packed [i][j] layout already places pixel (i,j) at slice 3*i+j.
    win = fin;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Line buffers are plain RAM with no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_a[rd_col] <= s_data;
      lb_b[rd_col] <= lb_a[rd_col];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_r    <= '0;
      in_c    <= '0;
      out_r   <= '0;
      out_c   <= '0;
      col_l   <= '0;
      col_c   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      m_err <= sof_err;
      if (accept) begin
        if (sof_err) begin
          // The offending pixel becomes p=0 of a new frame.
          in_r <= '0;
          in_c <= CW'(1);
        end else if (in_c == C_LAST) begin
          in_c <= '0;
          in_r <= (in_r == R_LAST) ? '0 : in_r + 1'b1;
        end else begin
          in_c <= in_c + 1'b1;
        end
      end
      if (shift) begin
        col_l <= col_c;
        col_c <= col_n;
      end
      if (sof_err) begin
        out_r   <= '0;
        out_c   <= '0;
        m_valid <= 1'b0;
      end else if (produce) begin
        m_valid <= 1'b1;
        m_data  <= win;
        m_sof   <= (out_r == '0) && (out_c == '0);
        m_eol   <= (out_c == C_LAST);
        m_eof   <= (out_r == R_LAST) && (out_c == C_LAST);
        if (out_c == C_LAST) begin
          out_c <= '0;
          out_r <= (out_r == R_LAST) ? '0 : out_r + 1'b1;
        end else begin
          out_c <= out_c + 1'b1;
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream neighbour of the conv datapath. Consumes a raster-order pixel stream and emits one 3x3 neighbourhood window per pixel position; the conv kernel multiplies each window.
- Border pixels are extended per cfg_pkg::EXTEND_STRATEGY ("ZERO_PAD" or "REPLICATE"), resolved at elaboration.
- Frame geometry is fixed by parameters. Internally: two line buffers, a 3x3 window register, and a fill/run/drain FSM.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 16, frame width in pixels (>=2)
IMG_H, 16, frame height in pixels (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, synchronous, active-high
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid&&s_ready
s_data  in  DATA_W  input pixel
s_sof  in  1  first pixel of frame
m_valid  out  1  window valid
m_ready  in  1  downstream accept
m_data  out  9*DATA_W  window; slice (3*i+j)*DATA_W holds pixel (r-1+i, c-1+j), i,j in 0..2
m_sof  out  1  window centred at (0,0)
m_eol  out  1  window centred at c=IMG_W-1
m_eof  out  1  window centred at (IMG_H-1, IMG_W-1)
m_err  out  1  one-cycle pulse: s_sof seen at nonzero input position

Behaviour:
- Reset: m_valid=0, m_sof=m_eol=m_eof=m_err=0, state=FILL, input/output position counters=0, s_ready=1 the cycle after rst deasserts. Line-buffer RAM is not reset and must never be visible at m_data (edges are masked).
- Input index p = r*IMG_W + c increments on each accepted beat. It wraps to 0 after IMG_W*IMG_H-1.
- FILL (p < IMG_W+1): accept pixels, emit nothing, s_ready=1.
  - Accepting p = IMG_W+1 moves to RUN and produces the window for centre (0,0).
- RUN: each accepted pixel p produces the window centred at output index p-(IMG_W+1).
  - Window is registered; m_valid rises the cycle after acceptance (latency 1 cycle from accept, IMG_W+1 pixels from window origin).
  - Accepting the last pixel (p = IMG_W*IMG_H-1) moves to DRAIN.
- DRAIN: s_ready=0. Emit the remaining IMG_W+1 windows without input, one per cycle while (!m_valid||m_ready). After the window with m_eof is accepted, go to FILL.
- Handshake:
  - m_valid/m_data/flags are held stable until m_ready.
  - s_ready = (state!=DRAIN) && (!m_valid || m_ready || state==FILL).
  - No combinational path from m_ready to m_valid.
- Boundary extension for an out-of-range neighbour (row<0, row>=IMG_H, col<0, col>=IMG_W):
  - ZERO_PAD: value 0.
  - REPLICATE: coordinates clamped to [0,IMG_H-1] x [0,IMG_W-1].
  - Row and column clamps are independent, so corners replicate the corner pixel.
- Column wrap: at c=IMG_W-1 the right column is out-of-range. The next window (c=0) must not reuse prior-row data in the left column.
- Flags: m_sof at output index 0; m_eol every IMG_W-th window; m_eof on the last window.
- s_sof accepted at p!=0: pulse m_err, discard the pending output window (m_valid=0 next cycle), reset to FILL, and treat the pixel as p=0.
- s_sof=0 at p=0 is accepted silently.
- Simultaneous output handshake and input accept in RUN: full throughput, 1 window/cycle.
- rst mid-frame or mid-drain: all state returns to reset values next cycle. Partial frame is lost; no spurious m_valid.

Test Plan:
- IMG_W=IMG_H=4, ZERO_PAD, pixels 1..16, m_ready=1 -> 16 windows.
  - First window {0,0,0,0,1,2,0,5,6} with m_sof, one cycle after 6th pixel accepted.
  - Last window {11,12,0,15,16,0,0,0,0} with m_eof and m_eol.
- Same stimulus, REPLICATE -> first window {1,1,2,1,1,2,5,5,6}; window (1,3) {3,4,4,7,8,8,11,12,12}; last window {11,12,12,15,16,16,15,16,16}.
- Random m_ready (50%) and random s_valid gaps, 4x4 ZERO_PAD -> identical 16-window sequence vs. model; m_data stable while m_valid&&!m_ready; s_ready=0 for all 5 drain windows.
- Two back-to-back 4x4 frames (1..16 then 101..116) -> 32 windows; second frame's first window {0,0,0,0,101,102,0,105,106}; no prior-frame data leaks.
- s_sof asserted on pixel index 7 -> m_err pulses once; subsequent 16 pixels form a clean frame with correct windows.
- rst asserted for one cycle after 9 pixels -> m_valid=0 next cycle; fresh frame produces the correct first window.
